aes_key_schedule: RTL and testbench
===================================

// Module: aes_key_schedule
// PURPOSE
//  Iterative AES key expander, one schedule word per clock; KEY_BITS selects 128/192/256 at elaboration.
//  Loads a cipher key on a start handshake and expands it into all 4*(Nr+1) words, held in an internal word array.
//  Serves any round key through a registered read port, so the cipher core needs no combinational per-round expansion.
//  Sits between the key-load interface and the AES round datapath.
// PARAMETERS
//  KEY_BITS  128  key length: 128, 192 or 256; Nk=KEY_BITS/32, Nr=Nk+6; other values are an elaboration error
// PORTS
//  clk       in   1    single clock, all state on rising edge
//  rst_n     in   1    asynchronous, active-low reset
//  start     in   1    request new expansion; key sampled same cycle when accepted
//  key_in    in   256  cipher key, MSB-aligned: key in [255:256-KEY_BITS], unused LSBs ignored
//  busy      out  1    expansion in progress
//  key_ready out  1    full schedule valid; held until next accepted start or reset
//  rd_en     in   1    round-key read request
//  rd_idx    in   4    round index 0..Nr
//  rd_valid  out  1    rd_key valid, 1 cycle after rd_en
//  rd_key    out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in [127:96]
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, key_ready=0, rd_valid=0, rd_key=0, rcon=8'h01, word counter=0; array contents don't-care.
//  FSM: IDLE -start-> LOAD -> EXPAND -(last word written)-> DONE -start-> LOAD.
//   IDLE: busy=0, key_ready=0. start accepted only in IDLE or DONE; start while busy is ignored, no queuing.
//   LOAD (1 cycle): writes key words w[0..Nk-1] from the registered key; i=Nk; rcon=01; key_ready drops to 0; busy=1.
//   EXPAND: one word per cycle, w[i]=w[i-Nk]^t:
//    i%Nk==0          : t=SubWord(RotWord(w[i-1]))^{rcon,24'h0}, then rcon=xtime(rcon) (x^8 reduction, poly 8'h1b)
//    Nk==8 && i%8==4  : t=SubWord(w[i-1])
//    otherwise        : t=w[i-1]
//   EXPAND ends after w[4*Nr+3]. Cycles in EXPAND: 40 / 46 / 52 for 128 / 192 / 256.
//   DONE: busy=0, key_ready=1.
//  Latency, start accepted to key_ready=1: 1 (capture) + 1 (LOAD) + EXPAND count = 42 / 48 / 54 cycles.
//  S-box: one 4-byte SubWord instance, shared between the two SubWord cases (mutually exclusive per cycle).
//  Word counter: 6 bits, max 59; modulo via a separate Nk-period counter, no divider.
//  Read port:
//   rd_valid <= rd_en & key_ready & (rd_idx<=Nr).
//   rd_key <= the addressed round key when that condition holds, else 128'h0.
//   Reads while busy return rd_valid=0, rd_key=0.
//   A start accepted in the same cycle as rd_en: the read sees the old schedule (key_ready still 1 that cycle).
//  Reset mid-expansion aborts to IDLE at once; no partial key_ready.
//  New start from DONE overwrites the array; old round keys are unavailable from the LOAD cycle on.
// CONFIGURATION
//  AES_KS_DECRYPT_ORDER_EN defined:
//   Adds input rd_rev (1b). When rd_rev=1 the port returns round Nr-rd_idx, giving decryption order from index 0 upward.
//   The range check applies to rd_idx before the mapping.
//  Undefined: no rd_rev port; rd_idx is always the forward round number.
// TESTING
//  KEY_BITS=128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c -> key_ready 42 cycles after start;
//   rd_idx=10 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
//  KEY_BITS=192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> key_ready at 48;
//   rd_idx=12 -> e98ba06f_448c773c_8ecc7204_01002202.
//  KEY_BITS=256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> key_ready at 54;
//   rd_idx=14 -> fe4890d1_e6188d0b_046df344_706c631e.
//  Start pulsed at cycle 10 of EXPAND -> ignored, same final schedule. rd_en while busy -> rd_valid=0, rd_key=0.
//   rd_idx=11 (128-bit) -> rd_valid=0, rd_key=0.
//  rst_n low at cycle 20 of EXPAND -> all outputs at reset values asynchronously.
//   Restart -> correct schedule. With AES_KS_DECRYPT_ORDER_EN: rd_rev=1, rd_idx=0 -> round-10 key.

Source files
------------

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expander (one word per clock) with a registered round-key read port.
// Define AES_KS_DECRYPT_ORDER_EN to add rd_rev, which serves round Nr-rd_idx (decryption order).

module aes_key_schedule #(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         key_ready,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
`ifdef AES_KS_DECRYPT_ORDER_EN
    input  logic         rd_rev,
`endif
    output logic         rd_valid,
    output logic [127:0] rd_key
);

    // state   | meaning
    // S_IDLE  | no schedule held, waiting for start
    // S_LOAD  | copy captured key into w[0..Nk-1], prime counters
    // S_EXPAND| derive w[i] for i = Nk .. 4*Nr+3, one per cycle
    // S_DONE  | schedule valid, read port live, start restarts

    localparam int NK   = KEY_BITS / 32;
    localparam int NR   = NK + 6;
    localparam int NW   = 4 * (NR + 1);
    localparam int LAST = NW - 1;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic [KEY_BITS-1:0]   r_key;
    logic [31:0]           r_w [NW];
    logic [5:0]            r_i;
    logic [2:0]            r_mod;
    logic [7:0]            r_rcon;
    logic                  r_rd_valid;
    logic [127:0]          r_rd_key;

    logic [31:0]           w_prev;
    logic [31:0]           w_back;
    logic [31:0]           w_sub_in;
    logic [31:0]           w_sub;
    logic [31:0]           w_temp;
    logic [31:0]           w_new;
    logic [3:0]            w_round;
    logic [5:0]            w_base;
    logic                  w_rd_ok;
    logic                  w_unused_key;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        busy      = 1'b0;
        key_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                busy   = 1'b1;
                w_next = S_EXPAND;
            end
            S_EXPAND: begin
                busy = 1'b1;
                if (r_i == 6'(LAST)) w_next = S_DONE;
            end
            S_DONE: begin
                key_ready = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // One shared SubWord: RotWord'd input on i%Nk==0, plain input on the AES-256 i%8==4 step.
    assign w_prev   = r_w[r_i - 6'd1];
    assign w_back   = r_w[r_i - 6'(NK)];
    assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_sub    = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                       sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};

    always_comb begin
        w_temp = w_prev;
        if (r_mod == 3'd0)                w_temp = w_sub ^ {r_rcon, 24'h0};
        else if (NK == 8 && r_mod == 3'd4) w_temp = w_sub;
    end

    assign w_new = w_back ^ w_temp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i    <= 6'd0;
            r_mod  <= 3'd0;
            r_rcon <= 8'h01;
        end else if (r_state == S_LOAD) begin
            r_i    <= 6'(NK);
            r_mod  <= 3'd0;
            r_rcon <= 8'h01;
        end else if (r_state == S_EXPAND) begin
            r_i   <= r_i + 6'd1;
            r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
            if (r_mod == 3'd0)
                r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        end
    end

    // Key register and word array carry no reset; their contents are only observed in S_DONE.
    always_ff @(posedge clk) begin
        if (w_accept) r_key <= key_in[255 -: KEY_BITS];
        if (r_state == S_LOAD) begin
            for (int j = 0; j < NK; j++) r_w[j] <= r_key[KEY_BITS-1-32*j -: 32];
        end else if (r_state == S_EXPAND) begin
            r_w[r_i] <= w_new;
        end
    end

`ifdef AES_KS_DECRYPT_ORDER_EN
    assign w_round = rd_rev ? (4'(NR) - rd_idx) : rd_idx;
`else
    assign w_round = rd_idx;
`endif
    assign w_base  = {w_round, 2'b00};
    assign w_rd_ok = rd_en && (r_state == S_DONE) && (rd_idx <= 4'(NR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_key   <= 128'h0;
        end else begin
            r_rd_valid <= w_rd_ok;
            r_rd_key   <= w_rd_ok ? {r_w[w_base], r_w[w_base + 6'd1],
                                     r_w[w_base + 6'd2], r_w[w_base + 6'd3]} : 128'h0;
        end
    end

    assign rd_valid     = r_rd_valid;
    assign rd_key       = r_rd_key;
    assign w_unused_key = ^key_in;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: runs 128/192/256-bit instances side by side against a FIPS-197 style reference model.
// Set AES_KS_DECRYPT_ORDER_EN to also exercise the rd_rev port.

module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_idx = 4'd0;
`ifdef AES_KS_DECRYPT_ORDER_EN
    logic         rd_rev = 1'b0;
`endif
    logic [255:0] key_in [3];
    logic         busy [3];
    logic         key_ready [3];
    logic         rd_valid [3];
    logic [127:0] rd_key [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  sbox_tab [256];
    logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [31:0] model_w [3][60];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_key_schedule #(.KEY_BITS(128 + 64 * g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .key_in    (key_in[g]),
            .busy      (busy[g]),
            .key_ready (key_ready[g]),
            .rd_en     (rd_en),
            .rd_idx    (rd_idx),
`ifdef AES_KS_DECRYPT_ORDER_EN
            .rd_rev    (rd_rev),
`endif
            .rd_valid  (rd_valid[g]),
            .rd_key    (rd_key[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] bb;
        p  = 8'h00;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) p = p ^ bb;
            bb = bb[7] ? ({bb[6:0], 1'b0} ^ 8'h1b) : {bb[6:0], 1'b0};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c63;
        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = 8'h00;
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c63[b];
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    task automatic model_expand(input int k, input logic [255:0] key);
        int nk;
        int nr;
        logic [31:0] t;
        nk = 4 + 2 * k;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) model_w[k][i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * nr + 4; i++) begin
            t = model_w[k][i-1];
            if (i % nk == 0)
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = sub_word(t);
            model_w[k][i] = model_w[k][i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] round_key(input int k, input int r);
        return {model_w[k][4*r], model_w[k][4*r+1], model_w[k][4*r+2], model_w[k][4*r+3]};
    endfunction

    task automatic random_keys();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 8; j++) key_in[k][32*j +: 32] = $urandom();
    endtask

    task automatic read1(input int idx);
        rd_en  = 1'b1;
        rd_idx = 4'(idx);
        @(posedge clk); #1;
        rd_en  = 1'b0;
    endtask

    task automatic read_all();
        for (int r = 0; r < 16; r++) begin
            read1(r);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rdv k%0d r%0d", k, r), 128'(rd_valid[k]), 128'(r <= 10 + 2*k));
                chk($sformatf("rdk k%0d r%0d", k, r), rd_key[k], (r <= 10 + 2*k) ? round_key(k, r) : 128'h0);
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(key_ready[0] && key_ready[1] && key_ready[2]) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done", 128'(key_ready[0] && key_ready[1] && key_ready[2]), 128'd1);
    endtask

    // mode 0: plain run; 1: stray start + read mid-EXPAND; 2: async reset mid-EXPAND (aborts)
    task automatic run(input int mode);
        int lat [3];
        logic [255:0] orig [3];
        for (int k = 0; k < 3; k++) begin
            model_expand(k, key_in[k]);
            orig[k] = key_in[k];
            lat[k]  = 0;
        end
        start = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("busy1 k%0d", k), 128'(busy[k]), 128'd1);
                    chk($sformatf("krdy1 k%0d", k), 128'(key_ready[k]), 128'd0);
                end
            end
            if (mode == 1 && n == 10) begin
                random_keys();
                start  = 1'b1;
                rd_en  = 1'b1;
                rd_idx = 4'd0;
            end
            if (mode == 1 && n == 11) begin
                start = 1'b0;
                rd_en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    key_in[k] = orig[k];
                    chk($sformatf("busyrdv k%0d", k), 128'(rd_valid[k]), 128'd0);
                    chk($sformatf("busyrdk k%0d", k), rd_key[k], 128'h0);
                end
            end
            if (mode == 2 && n == 20) begin
                #2 rst_n = 1'b0;
                #1;
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("arst busy k%0d", k), 128'(busy[k]), 128'd0);
                    chk($sformatf("arst krdy k%0d", k), 128'(key_ready[k]), 128'd0);
                    chk($sformatf("arst rdv k%0d", k), 128'(rd_valid[k]), 128'd0);
                    chk($sformatf("arst rdk k%0d", k), rd_key[k], 128'h0);
                end
                rst_n = 1'b1;
                @(posedge clk); #1;
                for (int k = 0; k < 3; k++)
                    chk($sformatf("post-arst busy k%0d", k), 128'(busy[k]), 128'd0);
                return;
            end
            for (int k = 0; k < 3; k++)
                if (key_ready[k] && lat[k] == 0) lat[k] = n;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("latency k%0d", k), 128'(lat[k]), 128'(42 + 6*k));
            chk($sformatf("idle busy k%0d", k), 128'(busy[k]), 128'd0);
        end
    endtask

    initial begin
        logic [127:0] old_rk [3];
        build_sbox();
        for (int k = 0; k < 3; k++) key_in[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst busy k%0d", k), 128'(busy[k]), 128'd0);
            chk($sformatf("rst krdy k%0d", k), 128'(key_ready[k]), 128'd0);
            chk($sformatf("rst rdv k%0d", k), 128'(rd_valid[k]), 128'd0);
            chk($sformatf("rst rdk k%0d", k), rd_key[k], 128'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        key_in[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        key_in[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        key_in[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        run(0);
        read1(10);
        chk("fips128 r10", rd_key[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read1(12);
        chk("fips192 r12", rd_key[1], 128'he98ba06f448c773c8ecc720401002202);
        read1(14);
        chk("fips256 r14", rd_key[2], 128'hfe4890d1e6188d0b046df344706c631e);
        read_all();

        repeat (3) begin
            random_keys();
            run(0);
            read_all();
        end

        random_keys();
        run(1);
        read_all();

        random_keys();
        run(2);
        random_keys();
        run(0);
        read_all();

        for (int k = 0; k < 3; k++) old_rk[k] = round_key(k, 1);
        random_keys();
        start  = 1'b1;
        rd_en  = 1'b1;
        rd_idx = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("samecyc rdv k%0d", k), 128'(rd_valid[k]), 128'd1);
            chk($sformatf("samecyc rdk k%0d", k), rd_key[k], old_rk[k]);
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("load rdv k%0d", k), 128'(rd_valid[k]), 128'd0);
            chk($sformatf("load rdk k%0d", k), rd_key[k], 128'h0);
            model_expand(k, key_in[k]);
        end
        wait_done();
        read_all();

`ifdef AES_KS_DECRYPT_ORDER_EN
        rd_rev = 1'b1;
        read1(0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("rev0 k%0d", k), rd_key[k], round_key(k, 10 + 2*k));
        read1(3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("rev3 k%0d", k), rd_key[k], round_key(k, 7 + 2*k));
        read1(15);
        for (int k = 0; k < 3; k++)
            chk($sformatf("rev15 k%0d", k), 128'(rd_valid[k]), 128'd0);
        rd_rev = 1'b0;
`endif

        read1(2);
        chk("pre-rst rdv", 128'(rd_valid[0]), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("done-rst krdy k%0d", k), 128'(key_ready[k]), 128'd0);
            chk($sformatf("done-rst rdv k%0d", k), 128'(rd_valid[k]), 128'd0);
            chk($sformatf("done-rst rdk k%0d", k), rd_key[k], 128'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
